program_loader: RTL and testbench

- Upstream feeder for the SAP-1 cpu programming port.
- Accepts a byte stream over a valid/ready handshake and writes it sequentially into the 16-word RAM through pr_mode, pr_address and pr_data.
- Holds the cpu in reset while loading and releases it on completion.
- Replaces manual switch-style programming so a host or UART receiver can load a program in one burst.

---
 rtl/program_loader.sv | 189 ++++++++++++++++++
 tb/tb_program_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
// ---------------------------------------------------------------------------
// Upstream feeder for the SAP-1 cpu programming port. It takes a byte stream
// from a host or UART receiver and writes it into the 16-word program RAM
// through pr_mode / pr_address / pr_data / pr_we. The cpu is held in reset
// (cpu_hold) for the whole load and released once the load completes.
//
// Optional build macro: LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the last program word. It must equal
//   the 8-bit (mod 256) sum of all written bytes. A match completes the load.
//   A mismatch sets error and returns to IDLE with no done pulse.
//   When undefined, the CKSUM state and the sum register do not exist.
//
// Parameters
//   ADDR_W     address width; 2**ADDR_W words are loaded per start
//   WR_CYCLES  cycles pr_we stays high per word (1..15)
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-low reset
//   start       begin a load (only looked at in IDLE)
//   abort       cancel the load in progress (beats every other event)
//   in_valid    in_data carries a byte
//   in_data     program byte
//   in_ready    loader accepts a byte this cycle
//   pr_mode     cpu programming address path select (1 = loader drives RAM)
//   pr_address  RAM address being written
//   pr_data     RAM write data
//   pr_we       RAM write strobe
//   cpu_hold    1 = cpu must be held in reset
//   busy        load in progress (state != IDLE)
//   done        one-cycle pulse on successful completion
//   error       sticky; set on abort or checksum failure, cleared by start
//   state_dbg   current FSM state, for debug and checkers:
//               0 IDLE, 1 RECV, 2 WRITE, 3 NEXT, 4 FINISH, 5 CKSUM
//
// Handshake: a byte moves on a rising clk edge where in_valid and in_ready are
// both high. in_ready comes from a register and never depends on in_valid in
// the same cycle, so a source may look at in_ready before raising in_valid.
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int ADDR_W    = 4,
  parameter int WR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              pr_mode,
  output logic [ADDR_W-1:0] pr_address,
  output logic [7:0]        pr_data,
  output logic              pr_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECV   = 3'd1,
    S_WRITE  = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4,
    S_CKSUM  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [3:0]        WR_LAST   = 4'(WR_CYCLES - 1);

  state_t     state;
  logic [3:0] wr_cnt;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      pr_mode    <= 1'b0;
      pr_address <= '0;
      pr_data    <= '0;
      pr_we      <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      wr_cnt     <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state != S_IDLE && abort) begin
        // Cancel immediately; RAM words already written are left in place.
        state    <= S_IDLE;
        in_ready <= 1'b0;
        pr_we    <= 1'b0;
        pr_mode  <= 1'b0;
        cpu_hold <= 1'b0;
        error    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            // abort in IDLE suppresses start and leaves error untouched.
            if (start && !abort) begin
              state      <= S_RECV;
              pr_address <= '0;
              error      <= 1'b0;
              pr_mode    <= 1'b1;
              cpu_hold   <= 1'b1;
              in_ready   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
              sum        <= '0;
`endif
            end
          end
          S_RECV: begin
            // in_ready is high throughout RECV, so in_valid alone is the handshake.
            if (in_valid) begin
              pr_data  <= in_data;
              in_ready <= 1'b0;
              pr_we    <= 1'b1;
              wr_cnt   <= '0;
              state    <= S_WRITE;
`ifdef LOADER_CHECKSUM_EN
              sum      <= sum + in_data;
`endif
            end
          end
          S_WRITE: begin
            if (wr_cnt == WR_LAST) begin
              pr_we <= 1'b0;
              state <= S_NEXT;
            end else begin
              wr_cnt <= wr_cnt + 4'd1;
            end
          end
          S_NEXT: begin
            // Address and data hold through this cycle after the strobe drops.
            if (pr_address == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
              state    <= S_CKSUM;
              in_ready <= 1'b1;
`else
              state    <= S_FINISH;
              done     <= 1'b1;
`endif
            end else begin
              pr_address <= pr_address + 1'b1;
              in_ready   <= 1'b1;
              state      <= S_RECV;
            end
          end
          S_FINISH: begin
            state    <= S_IDLE;
            pr_mode  <= 1'b0;
            cpu_hold <= 1'b0;
          end
`ifdef LOADER_CHECKSUM_EN
          S_CKSUM: begin
            if (in_valid) begin
              in_ready <= 1'b0;
              if (in_data == sum) begin
                state <= S_FINISH;
                done  <= 1'b1;
              end else begin
                state    <= S_IDLE;
                error    <= 1'b1;
                pr_mode  <= 1'b0;
                cpu_hold <= 1'b0;
              end
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
module tb_program_loader;
  localparam int ADDR_W    = 4;
  localparam int WR_CYCLES = 2;
  localparam int WORDS     = 1 << ADDR_W;
  localparam int TIMEOUT   = 2000;
`ifdef LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              pr_mode;
  logic [ADDR_W-1:0] pr_address;
  logic [7:0]        pr_data;
  logic              pr_we;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [2:0]        state_dbg;

  program_loader #(.ADDR_W(ADDR_W), .WR_CYCLES(WR_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pr_mode(pr_mode), .pr_address(pr_address), .pr_data(pr_data),
    .pr_we(pr_we), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .error(error), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model: stream, expected writes, RAM ----------------
  logic [7:0]  stream [0:WORDS];
  int          n_bytes;
  logic [11:0] exp_q[$];             // {address, data} in the order writes must occur
  logic [7:0]  ram [0:WORDS-1];      // image of the cpu RAM as the loader wrote it

  task automatic push_exp(input int n_words);
    for (int i = 0; i < n_words; i++) exp_q.push_back({4'(i), stream[i]});
  endtask

  function automatic logic [7:0] model_sum(input int n);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < n; i++) s = s + stream[i];
    return s;
  endfunction

  // ---------------- scoreboard / per-cycle compare ----------------
  logic [ADDR_W-1:0] we_addr;
  logic [7:0]        we_data;
  int                we_len = 0;

  always @(negedge clk) begin
    if (!rst) begin
      we_len = 0;
    end else begin
      check("hold_mode_track_busy", {cpu_hold, pr_mode}, {busy, busy});
      check("ready_only_when_receiving", in_ready && (!busy || pr_we), 1'b0);
      check("we_or_done_outside_load", (pr_we || done) && !busy, 1'b0);
      if (pr_we) begin
        if (we_len == 0) begin
          we_addr = pr_address;
          we_data = pr_data;
        end else begin
          check("strobe_addr_data_stable", {pr_address, pr_data}, {we_addr, we_data});
        end
        we_len++;
      end else if (we_len > 0) begin
        check("hold_after_strobe", {pr_address, pr_data}, {we_addr, we_data});
        check("strobe_length", we_len, WR_CYCLES);
        if (exp_q.size() == 0) begin
          check("write_unexpected", {we_addr, we_data}, 12'hFFF);
        end else begin
          check("write_addr_data", {we_addr, we_data}, exp_q.pop_front());
        end
        ram[we_addr] = we_data;
        we_len = 0;
      end
    end
  end

  // ---------------- driver ----------------
  // Pulses start, then feeds stream[] with in_valid every gap-th cycle.
  // Returns at the done cycle, when the load ends without done, after an
  // injected abort, or after an injected asynchronous reset.
  task automatic run_load(input int gap, input int abort_word, input int start_word,
                          input int reset_word, output int done_cnt, output int cycles);
    int  idx;
    int  first;
    int  wc;
    bit  hs;
    done_cnt = 0;
    cycles   = -1;
    idx      = 0;
    first    = -1;
    wc       = 0;
    abort    = 1'b0;
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= TIMEOUT; k++) begin
      start = 1'b0;
      if (busy && first < 0) first = k;
      wc = pr_we ? wc + 1 : 0;
      if (done) begin
        done_cnt++;
        cycles = k - first;
        return;
      end
      if (first >= 0 && !busy) begin
        in_valid = 1'b0;
        return;
      end
      if (pr_we && int'(pr_address) == abort_word && wc == 2) begin
        abort    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        return;
      end
      if (pr_we && int'(pr_address) == reset_word && wc == 1) begin
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_rst_pr_we", pr_we, 1'b0);
        check("async_rst_pr_mode", pr_mode, 1'b0);
        check("async_rst_cpu_hold", cpu_hold, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        return;
      end
      if (pr_we && int'(pr_address) == start_word && wc == 1) start = 1'b1;
      in_valid = ((k % gap) == 0);
      if (idx < n_bytes) begin
        in_data = stream[idx];
      end else begin
        in_data = 8'hEE;
        if (gap != 1) in_valid = 1'b0;
      end
      hs = in_valid && in_ready;
      @(negedge clk);
      if (hs) idx++;
    end
    check("load_timeout", 1'b1, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_pr_we"}, pr_we, 1'b0);
    check({tag, "_cpu_hold"}, cpu_hold, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- directed tests ----------------
  int dc;
  int cyc;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_pr_mode", pr_mode, 1'b0);
    check("reset_error", error, 1'b0);
    check("reset_addr_data", {pr_address, pr_data}, 12'h000);
    #2 rst = 1'b1;
    @(negedge clk);

    // 1: bytes 0x00..0x0F, in_valid held high
    for (int i = 0; i < WORDS; i++) stream[i] = 8'(i);
    stream[WORDS] = model_sum(WORDS);
    n_bytes = WORDS + CK;
    check("model_sum_0_to_15", model_sum(WORDS), 8'h78);
    push_exp(WORDS);
    run_load(1, -1, -1, -1, dc, cyc);
    check("t1_done_count", dc, 1);
    check("t1_cycles", cyc, WORDS * (WR_CYCLES + 2) + CK);
`ifndef LOADER_CHECKSUM_EN
    check("t1_cycles_literal", cyc, 64);
`endif
    check("t1_ready_at_done", in_ready, 1'b0);
    check("t1_hold_at_done", cpu_hold, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check_idle_outputs("t1_after_done");
    check("t1_error", error, 1'b0);
    check("t1_writes_left", exp_q.size(), 0);
    check("t1_ram15", ram[15], 8'h0F);
    check("t1_ram7", ram[7], 8'h07);

    // 2: throttled source, in_valid every 5th cycle
    for (int i = 0; i < WORDS; i++) stream[i] = 8'h5A ^ 8'(i * 19);
    stream[WORDS] = model_sum(WORDS);
    push_exp(WORDS);
    run_load(5, -1, -1, -1, dc, cyc);
    check("t2_done_count", dc, 1);
    @(negedge clk);
    check("t2_writes_left", exp_q.size(), 0);
    for (int i = 0; i < WORDS; i++) check("t2_ram_image", ram[i], stream[i]);
    check("t2_ram0_literal", ram[0], 8'h5A);
    check("t2_ram1_literal", ram[1], 8'h49);

    // 3: abort in the 2nd strobe cycle of word 7
    for (int i = 0; i < WORDS; i++) stream[i] = 8'hC0 + 8'(i);
    stream[WORDS] = model_sum(WORDS);
    push_exp(8);
    run_load(1, 7, -1, -1, dc, cyc);
    check("t3_pr_we_after_abort", pr_we, 1'b0);
    check("t3_busy_after_abort", busy, 1'b0);
    check("t3_error_after_abort", error, 1'b1);
    check("t3_no_done", {28'd0, done} | 32'(dc), 0);
    @(negedge clk);
    check("t3_writes_left", exp_q.size(), 0);
    check("t3_ram7_kept", ram[7], 8'hC7);

    // start and abort together in IDLE: abort wins, error unchanged
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 1'b0);
    check("start_abort_error", error, 1'b1);
    @(negedge clk);

    // 4: start pulsed during word 3 is ignored; this start clears error
    for (int i = 0; i < WORDS; i++) stream[i] = 8'hFF - 8'(i * 3);
    stream[WORDS] = model_sum(WORDS);
    push_exp(WORDS);
    run_load(1, -1, 3, -1, dc, cyc);
    check("t4_done_count", dc, 1);
    check("t4_error_cleared", error, 1'b0);
    check("t4_cycles", cyc, WORDS * (WR_CYCLES + 2) + CK);
    @(negedge clk);
    check("t4_writes_left", exp_q.size(), 0);

    // 5: async reset during word 5, then a clean load from address 0
    for (int i = 0; i < WORDS; i++) stream[i] = 8'h11 * 8'(i + 1);
    stream[WORDS] = model_sum(WORDS);
    push_exp(5);
    run_load(1, -1, -1, 5, dc, cyc);
    @(negedge clk);
    check_idle_outputs("t5_after_reset");
    check("t5_addr_after_reset", pr_address, 4'h0);
    check("t5_writes_left", exp_q.size(), 0);
    push_exp(WORDS);
    run_load(1, -1, -1, -1, dc, cyc);
    check("t5_done_count", dc, 1);
    @(negedge clk);
    check("t5_reload_writes_left", exp_q.size(), 0);
    check("t5_ram0", ram[0], 8'h11);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum over 0x01 x16
    for (int i = 0; i < WORDS; i++) stream[i] = 8'h01;
    stream[WORDS] = 8'h10;
    check("t6_model_sum", model_sum(WORDS), 8'h10);
    push_exp(WORDS);
    run_load(1, -1, -1, -1, dc, cyc);
    check("t6_good_done", dc, 1);
    check("t6_good_error", error, 1'b0);
    @(negedge clk);
    stream[WORDS] = 8'h11;
    push_exp(WORDS);
    run_load(1, -1, -1, -1, dc, cyc);
    check("t6_bad_no_done", dc, 0);
    check("t6_bad_error", error, 1'b1);
    check("t6_bad_busy", busy, 1'b0);
    @(negedge clk);
    check("t6_writes_left", exp_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
